// File: rtl/selftest_pkg.sv
// Shared types and helpers for the nand_cpu self-test sequencer.
// Compare modes, FSM states, LFSR taps and the reference comparison.
package selftest_pkg;

   typedef enum logic [1:0] {
      SLT = 2'd0,
      ULT = 2'd1,
      EQ  = 2'd2,
      ULE = 2'd3
   } cmp_mode_t;

   typedef enum logic [3:0] {
      IDLE,
      HOLD,
      GEN0,
      GEN1,
      WRITE,
      RUN,
      READ,
      CHECK,
      DONE
   } state_t;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   // Operands are left-justified so a plain 32-bit signed compare
   // orders narrower two's-complement values correctly.
   function automatic logic expected_result(
      cmp_mode_t   m,
      logic [31:0] a,
      logic [31:0] b,
      int unsigned width
   );
      logic [31:0]        mask;
      logic [31:0]        ua;
      logic [31:0]        ub;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      int unsigned        sh;
      logic               r;
      sh   = 32 - width;
      mask = 32'hFFFF_FFFF >> sh;
      ua   = a & mask;
      ub   = b & mask;
      sa   = $signed(ua << sh);
      sb   = $signed(ub << sh);
      r    = 1'b0;
      unique case (m)
         SLT: r = (sa < sb);
         ULT: r = (ua < ub);
         EQ:  r = (ua == ub);
         ULE: r = (ua <= ub);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [15:0] sat_inc(logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/cpu_selftest_seq_if.sv
// Bus between the self-test sequencer and the nand_cpu side:
// CPU reset/halt plus the byte-wide D_MEM port.
interface cpu_selftest_seq_if;

   logic       cpu_n_rst;
   logic       cpu_halt;
   logic       dmem_we;
   logic       dmem_re;
   logic [7:0] dmem_addr;
   logic [7:0] dmem_wdata;
   logic [7:0] dmem_rdata;

   modport master (
      output cpu_n_rst,
      output dmem_we,
      output dmem_re,
      output dmem_addr,
      output dmem_wdata,
      input  cpu_halt,
      input  dmem_rdata
   );

   modport slave (
      input  cpu_n_rst,
      input  dmem_we,
      input  dmem_re,
      input  dmem_addr,
      input  dmem_wdata,
      output cpu_halt,
      output dmem_rdata
   );

endinterface

// File: rtl/cpu_selftest_seq_lfsr32.sv
// 32-bit Galois LFSR operand source; a zero seed loads as 1.
// Exposes the next-state value so a draw and its step share a cycle.
module lfsr32
   import selftest_pkg::*;
#(
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [31:0]      seed,
   output logic [OUT_W-1:0] word,
   output logic [1:0]       top
);

   logic [31:0] state;
   logic [31:0] nxt;

   assign nxt  = {1'b0, state[31:1]}
               ^ (state[0] ? LFSR_TAPS : 32'h0);
   assign word = nxt[OUT_W-1:0];
   assign top  = nxt[31:30];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= 32'h1;
      end else if (load) begin
         state <= (seed == 32'h0) ? 32'h1 : seed;
      end else if (en) begin
         state <= nxt;
      end
   end

endmodule

// File: rtl/cpu_selftest_seq.sv
// Self-test sequencer for nand_cpu comparison programs.
// Define SELFTEST_STOP_ON_FAIL_EN to end a run at the first failure.
module cpu_selftest_seq
   import selftest_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int NUM_TESTS   = 64,
   parameter int RESULT_ADDR = 2 * DATA_W / 8,
   parameter int TIMEOUT     = 4096,
   parameter int RST_CYCLES  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [31:0]        seed,
   cpu_selftest_seq_if.master bus,
   output logic               busy,
   output logic               done,
   output logic [15:0]        pass_count,
   output logic [15:0]        fail_count,
   output logic [15:0]        timeout_count
);

   localparam int          NB     = 2 * (DATA_W / 8);
   localparam logic [7:0]  RES_A  = 8'(RESULT_ADDR);
   localparam logic [7:0]  LAST_B = 8'(NB - 1);
   localparam logic [31:0] TMAX   = 32'(TIMEOUT - 1);
   localparam logic [15:0] HMAX   = 16'(RST_CYCLES - 1);

   state_t            st;
   cmp_mode_t         mode_q;
   logic [DATA_W-1:0] op0;
   logic [DATA_W-1:0] op1;
   logic              eq_flag;
   logic [15:0]       idx;
   logic [15:0]       hold_cnt;
   logic [7:0]        bcnt;
   logic [31:0]       timer;

   logic              idle;
   logic              lfsr_en;
   logic [DATA_W-1:0] rnd;
   logic [1:0]        rnd_top;
   logic [2*DATA_W-1:0] ops;
   logic [7:0]        nxt_byte;
   logic              hit;
   logic              to_now;
   logic              pass_now;
   logic              fail_now;
   logic              end_test;
   logic              last;
   logic              stop;

   assign idle    = (st == IDLE) || (st == DONE);
   assign lfsr_en = (st == GEN0) || (st == GEN1);
   assign ops     = {op1, op0};

   lfsr32 #(
      .OUT_W (DATA_W)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .en   (lfsr_en),
      .load (idle && start),
      .seed (seed),
      .word (rnd),
      .top  (rnd_top)
   );

   always_comb begin
      nxt_byte = 8'(ops >> {bcnt + 8'd1, 3'b000});
      hit      = bus.dmem_rdata[0]
               == expected_result(mode_q, 32'(op0), 32'(op1), DATA_W);
      // Halt in the final timer cycle still counts as a halt.
      to_now   = (st == RUN) && !bus.cpu_halt && (timer == TMAX);
      pass_now = (st == CHECK) && hit;
      fail_now = ((st == CHECK) && !hit) || to_now;
      end_test = pass_now || fail_now;
      last     = (17'(idx) + 17'd1) >= 17'(NUM_TESTS);
`ifdef SELFTEST_STOP_ON_FAIL_EN
      stop     = last || fail_now;
`else
      stop     = last;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st             <= IDLE;
         mode_q         <= SLT;
         op0            <= '0;
         op1            <= '0;
         eq_flag        <= 1'b0;
         idx            <= '0;
         hold_cnt       <= '0;
         bcnt           <= '0;
         timer          <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass_count     <= '0;
         fail_count     <= '0;
         timeout_count  <= '0;
         bus.cpu_n_rst  <= 1'b0;
         bus.dmem_we    <= 1'b0;
         bus.dmem_re    <= 1'b0;
         bus.dmem_addr  <= '0;
         bus.dmem_wdata <= '0;
      end else if (end_test) begin
         if (pass_now) pass_count <= sat_inc(pass_count);
         if (fail_now) fail_count <= sat_inc(fail_count);
         if (to_now) timeout_count <= sat_inc(timeout_count);
         bus.cpu_n_rst <= 1'b0;
         if (stop) begin
            st   <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
         end else begin
            st       <= HOLD;
            hold_cnt <= '0;
            idx      <= idx + 16'd1;
         end
      end else begin
         unique case (st)
            IDLE, DONE: begin
               if (start) begin
                  mode_q        <= cmp_mode_t'(mode);
                  pass_count    <= '0;
                  fail_count    <= '0;
                  timeout_count <= '0;
                  idx           <= '0;
                  hold_cnt      <= '0;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  st            <= HOLD;
               end
            end
            HOLD: begin
               if (hold_cnt == HMAX) st <= GEN0;
               else hold_cnt <= hold_cnt + 16'd1;
            end
            GEN0: begin
               op0     <= rnd;
               eq_flag <= (rnd_top == 2'b00);
               st      <= GEN1;
            end
            GEN1: begin
               op1            <= eq_flag ? op0 : rnd;
               bcnt           <= '0;
               bus.dmem_we    <= 1'b1;
               bus.dmem_addr  <= '0;
               bus.dmem_wdata <= op0[7:0];
               st             <= WRITE;
            end
            WRITE: begin
               if (bcnt == LAST_B) begin
                  bus.dmem_we   <= 1'b0;
                  bus.cpu_n_rst <= 1'b1;
                  timer         <= '0;
                  st            <= RUN;
               end else begin
                  bcnt           <= bcnt + 8'd1;
                  bus.dmem_addr  <= bcnt + 8'd1;
                  bus.dmem_wdata <= nxt_byte;
               end
            end
            RUN: begin
               if (bus.cpu_halt) begin
                  bus.cpu_n_rst <= 1'b0;
                  bus.dmem_re   <= 1'b1;
                  bus.dmem_addr <= RES_A;
                  st            <= READ;
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            READ: begin
               bus.dmem_re <= 1'b0;
               st          <= CHECK;
            end
            CHECK: st <= CHECK;
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_selftest_seq.sv
// Bench for cpu_selftest_seq: behavioural nand_cpu responders on two
// instances (16-bit/64 tests and 32-bit/3 tests/short timeout).
module tb_cpu_selftest_seq;

   localparam int NT_A = 64;
   localparam int NT_B = 3;
   localparam int TO_B = 16;
   localparam int RSTC = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic [1:0]  mode_a = 2'd0;
   logic [1:0]  mode_b = 2'd0;
   logic [31:0] seed_a = 32'd1;
   logic [31:0] seed_b = 32'd1;
   logic        busy_a, done_a, busy_b, done_b;
   logic [15:0] pass_a, fail_a, tmo_a;
   logic [15:0] pass_b, fail_b, tmo_b;

   cpu_selftest_seq_if ia ();
   cpu_selftest_seq_if ib ();

   cpu_selftest_seq #(
      .DATA_W(16), .NUM_TESTS(NT_A), .RST_CYCLES(RSTC)
   ) ua (
      .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
      .seed(seed_a), .bus(ia.master), .busy(busy_a), .done(done_a),
      .pass_count(pass_a), .fail_count(fail_a), .timeout_count(tmo_a)
   );

   cpu_selftest_seq #(
      .DATA_W(32), .NUM_TESTS(NT_B), .TIMEOUT(TO_B), .RST_CYCLES(RSTC)
   ) ub (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
      .seed(seed_b), .bus(ib.master), .busy(busy_b), .done(done_b),
      .pass_count(pass_b), .fail_count(fail_b), .timeout_count(tmo_b)
   );

   int n_chk = 0;
   int n_fail = 0;

   // beh: 0 correct answer, 1 always 0, 2 wrong only on the third test
   int   beh_a = 0;
   int   beh_b = 0;
   logic hang_b = 1'b0;

   logic [7:0]  mem_a [256];
   logic [7:0]  mem_b [256];
   logic [7:0]  rd_a = 8'd0;
   logic [7:0]  rd_b = 8'd0;
   logic        halt_a = 1'b0;
   logic        halt_b = 1'b0;
   int          cnt_a = 0, dly_a = 1, nt_a = 0;
   int          cnt_b = 0, dly_b = 1, nt_b = 0;
   logic [15:0] wr_b [$];

   assign ia.dmem_rdata = rd_a;
   assign ia.cpu_halt   = halt_a;
   assign ib.dmem_rdata = rd_b;
   assign ib.cpu_halt   = halt_b;

   function automatic logic [31:0] step(logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic ref_cmp(int m, longint a, longint b, int w);
      longint full, sa, sb;
      full = longint'(1) << w;
      sa = (a >= full / 2) ? a - full : a;
      sb = (b >= full / 2) ? b - full : b;
      case (m)
         0: return sa < sb;
         1: return a < b;
         2: return a == b;
         default: return a <= b;
      endcase
   endfunction

   function automatic logic cpu_bit(int beh, int m, longint a,
                                    longint b, int w, int nt);
      logic r;
      r = ref_cmp(m, a, b, w);
      if (beh == 1) return 1'b0;
      if (beh == 2 && nt == 2) return !r;
      return r;
   endfunction

   always @(posedge clk) begin
      if (start_a) nt_a <= 0;
      if (ia.dmem_we) mem_a[ia.dmem_addr] <= ia.dmem_wdata;
      if (ia.dmem_re) rd_a <= mem_a[ia.dmem_addr];
      if (!ia.cpu_n_rst) begin
         halt_a <= 1'b0;
         cnt_a  <= 0;
         dly_a  <= int'($urandom_range(6, 1));
      end else if (!halt_a) begin
         if (cnt_a >= dly_a) begin
            mem_a[4] <= {7'd0, cpu_bit(beh_a, int'(mode_a),
               longint'({mem_a[1], mem_a[0]}),
               longint'({mem_a[3], mem_a[2]}), 16, nt_a)};
            halt_a <= 1'b1;
            nt_a   <= nt_a + 1;
         end else begin
            cnt_a <= cnt_a + 1;
         end
      end
   end

   always @(posedge clk) begin
      if (start_b) nt_b <= 0;
      if (ib.dmem_we) begin
         mem_b[ib.dmem_addr] <= ib.dmem_wdata;
         wr_b.push_back({ib.dmem_addr, ib.dmem_wdata});
      end
      if (ib.dmem_re) rd_b <= mem_b[ib.dmem_addr];
      if (!ib.cpu_n_rst) begin
         halt_b <= 1'b0;
         cnt_b  <= 0;
         dly_b  <= int'($urandom_range(6, 1));
      end else if (!halt_b && !hang_b) begin
         if (cnt_b >= dly_b) begin
            mem_b[8] <= {7'd0, cpu_bit(beh_b, int'(mode_b),
               longint'({mem_b[3], mem_b[2], mem_b[1], mem_b[0]}),
               longint'({mem_b[7], mem_b[6], mem_b[5], mem_b[4]}),
               32, nt_b)};
            halt_b <= 1'b1;
            nt_b   <= nt_b + 1;
         end else begin
            cnt_b <= cnt_b + 1;
         end
      end
   end

   task automatic predict(input int m, input logic [31:0] sd,
                          input int n, input int w, input int beh,
                          input logic hang, output int p, output int f,
                          output int t, output int ran);
      logic [31:0] s, a, b, mask;
      logic        eq, ok;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      s = (sd == 32'h0) ? 32'h1 : sd;
      p = 0; f = 0; t = 0; ran = 0;
      for (int i = 0; i < n; i++) begin
         s  = step(s);
         a  = s & mask;
         eq = (s[31:30] == 2'b00);
         s  = step(s);
         b  = eq ? a : (s & mask);
         ran++;
         if (hang) begin
            f++; t++; ok = 1'b0;
         end else begin
            ok = cpu_bit(beh, m, longint'(a), longint'(b), w, i)
                 == ref_cmp(m, longint'(a), longint'(b), w);
            if (ok) p++;
            else f++;
         end
`ifdef SELFTEST_STOP_ON_FAIL_EN
         if (!ok) break;
`endif
      end
   endtask

   task automatic run_a(input logic [1:0] m, input logic [31:0] s,
                        input int b);
      @(negedge clk);
      mode_a = m; seed_a = s; beh_a = b; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int i = 0; i < 20000 && !done_a; i++) @(negedge clk);
      n_chk++;
      if (!done_a) begin
         n_fail++;
         $display("FAIL run_a_done: got %0b want 1", done_a);
      end
   endtask

   task automatic run_b(input logic [1:0] m, input logic [31:0] s,
                        input int b);
      @(negedge clk);
      mode_b = m; seed_b = s; beh_b = b; start_b = 1'b1;
      wr_b.delete();
      @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < 2000 && !done_b; i++) @(negedge clk);
      n_chk++;
      if (!done_b) begin
         n_fail++;
         $display("FAIL run_b_done: got %0b want 1", done_b);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({ia.cpu_n_rst, ia.dmem_we, ia.dmem_re} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_bus_a: got %b want 000",
                  {ia.cpu_n_rst, ia.dmem_we, ia.dmem_re});
      end
      n_chk++;
      if ({busy_a, done_a, busy_b, done_b} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 0000",
                  {busy_a, done_a, busy_b, done_b});
      end
      n_chk++;
      if ({pass_a, fail_a, tmo_a} !== 48'h0) begin
         n_fail++;
         $display("FAIL reset_counts: got %h want 0",
                  {pass_a, fail_a, tmo_a});
      end
      n_chk++;
      if ({ib.cpu_n_rst, ib.dmem_we, ib.dmem_re} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_bus_b: got %b want 000",
                  {ib.cpu_n_rst, ib.dmem_we, ib.dmem_re});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_slt_correct();
      int p, f, t, r;
      run_a(2'd0, 32'hACE1, 0);
      predict(0, 32'hACE1, NT_A, 16, 0, 1'b0, p, f, t, r);
      n_chk++;
      if (pass_a !== 16'(p) || fail_a !== 16'(f) || tmo_a !== 16'(t)) begin
         n_fail++;
         $display("FAIL slt_counts: got %0d/%0d/%0d want %0d/%0d/%0d",
                  pass_a, fail_a, tmo_a, p, f, t);
      end
      n_chk++;
      if ({busy_a, done_a} !== 2'b01) begin
         n_fail++;
         $display("FAIL slt_flags: got %b want 01", {busy_a, done_a});
      end
   endtask

   task automatic test_eq_zero();
      int p, f, t, r;
      run_a(2'd2, 32'h1, 1);
      predict(2, 32'h1, NT_A, 16, 1, 1'b0, p, f, t, r);
      n_chk++;
      if (fail_a !== 16'(f) || pass_a !== 16'(p)) begin
         n_fail++;
         $display("FAIL eq_zero: got %0d/%0d want %0d/%0d",
                  pass_a, fail_a, p, f);
      end
   endtask

   task automatic test_random_modes();
      int p, f, t, r;
      logic [1:0]  m;
      logic [31:0] s;
      for (int k = 0; k < 4; k++) begin
         m = 2'($urandom_range(3, 0));
         s = $urandom;
         run_a(m, s, 1);
         predict(int'(m), s, NT_A, 16, 1, 1'b0, p, f, t, r);
         n_chk++;
         if (fail_a !== 16'(f) || pass_a !== 16'(p)) begin
            n_fail++;
            $display("FAIL rand_mode%0d seed %h: got %0d/%0d want %0d/%0d",
                     m, s, pass_a, fail_a, p, f);
         end
      end
   endtask

   task automatic test_timeout();
      int p, f, t, r, n, hi;
      hang_b = 1'b1;
      @(negedge clk);
      mode_b = 2'($urandom_range(3, 0));
      seed_b = $urandom;
      start_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_b = 1'b0;
      n = 0; hi = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (ib.cpu_n_rst) hi++;
         if (done_b) break;
      end
      predict(0, seed_b, NT_B, 32, 0, 1'b1, p, f, t, r);
      n_chk++;
      if (!done_b || n != r * (RSTC + 2 + 8 + TO_B)) begin
         n_fail++;
         $display("FAIL timeout_cycles: got %0d done %0b want %0d",
                  n, done_b, r * (RSTC + 2 + 8 + TO_B));
      end
      n_chk++;
      if (hi != r * TO_B) begin
         n_fail++;
         $display("FAIL timeout_nrst_high: got %0d want %0d", hi, r * TO_B);
      end
      n_chk++;
      if (tmo_b !== 16'(t) || fail_b !== 16'(f) || pass_b !== 16'(p)) begin
         n_fail++;
         $display("FAIL timeout_counts: got %0d/%0d/%0d want %0d/%0d/%0d",
                  pass_b, fail_b, tmo_b, p, f, t);
      end
      hang_b = 1'b0;
   endtask

   task automatic test_wide_bytes();
      int p, f, t, r;
      logic [31:0] s, a, b;
      logic [63:0] exp_ops;
      logic [7:0]  eb;
      s = step(32'h0040_0007);
      a = s;
      s = step(s);
      b = (a[31:30] == 2'b00) ? a : s;
      exp_ops = {b, a};
      for (int md = 0; md < 2; md++) begin
         run_b(2'(md), 32'h0040_0007, 1);
         n_chk++;
         if (wr_b.size() < 8) begin
            n_fail++;
            $display("FAIL wide_write_count: got %0d want 8", wr_b.size());
         end else begin
            for (int i = 0; i < 8; i++) begin
               eb = exp_ops[8*i +: 8];
               n_chk++;
               if (wr_b[i] !== {8'(i), eb}) begin
                  n_fail++;
                  $display("FAIL wide_byte%0d: got %h want %h",
                           i, wr_b[i], {8'(i), eb});
               end
            end
         end
         predict(md, 32'h0040_0007, NT_B, 32, 1, 1'b0, p, f, t, r);
         n_chk++;
         if (pass_b !== 16'(p) || fail_b !== 16'(f)) begin
            n_fail++;
            $display("FAIL wide_mode%0d: got %0d/%0d want %0d/%0d",
                     md, pass_b, fail_b, p, f);
         end
      end
      n_chk++;
      if (selftest_pkg::expected_result(selftest_pkg::SLT,
             32'h8000_0000, 32'h1, 32) !== 1'b1) begin
         n_fail++;
         $display("FAIL wide_slt_fn: got 0 want 1");
      end
      n_chk++;
      if (selftest_pkg::expected_result(selftest_pkg::ULT,
             32'h8000_0000, 32'h1, 32) !== 1'b0) begin
         n_fail++;
         $display("FAIL wide_ult_fn: got 1 want 0");
      end
   endtask

   task automatic test_reset_mid_run();
      int p, f, t, r, rises;
      logic prev;
      @(negedge clk);
      mode_a = 2'd0; seed_a = $urandom; beh_a = 0; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      rises = 0; prev = 1'b0;
      for (int i = 0; i < 5000 && rises < 5; i++) begin
         if (ia.cpu_n_rst && !prev) rises++;
         prev = ia.cpu_n_rst;
         if (rises < 5) @(negedge clk);
      end
      n_chk++;
      if (rises != 5 || pass_a !== 16'd4) begin
         n_fail++;
         $display("FAIL midrun_reach: got rises %0d pass %0d want 5/4",
                  rises, pass_a);
      end
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({ia.cpu_n_rst, busy_a, done_a} !== 3'b000
          || {pass_a, fail_a, tmo_a} !== 48'h0) begin
         n_fail++;
         $display("FAIL midrun_abort: got %b %h want 000 0",
                  {ia.cpu_n_rst, busy_a, done_a}, {pass_a, fail_a, tmo_a});
      end
      rst = 1'b0;
      run_a(2'd2, 32'h0, 1);
      predict(2, 32'h1, NT_A, 16, 1, 1'b0, p, f, t, r);
      n_chk++;
      if (pass_a !== 16'(p) || fail_a !== 16'(f)) begin
         n_fail++;
         $display("FAIL midrun_seed0: got %0d/%0d want %0d/%0d",
                  pass_a, fail_a, p, f);
      end
   endtask

   task automatic test_stop_on_fail();
      int p, f, t, r;
      logic [1:0]  m;
      logic [31:0] s;
      m = 2'($urandom_range(3, 0));
      s = $urandom;
      run_a(m, s, 2);
      predict(int'(m), s, NT_A, 16, 2, 1'b0, p, f, t, r);
      n_chk++;
      if (pass_a !== 16'(p) || fail_a !== 16'(f) || tmo_a !== 16'd0) begin
         n_fail++;
         $display("FAIL stop_on_fail: got %0d/%0d/%0d want %0d/%0d/0",
                  pass_a, fail_a, tmo_a, p, f);
      end
   endtask

   initial begin
      test_reset();
      test_slt_correct();
      test_eq_zero();
      test_random_modes();
      test_timeout();
      test_wide_bytes();
      test_reset_mid_run();
      test_stop_on_fail();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
